// File: rtl/fpga_cfg_pkg.sv
// Shared types and defaults for the fpga config-chain loader.
// Optional feature macro: CFG_CHECK_EN (frame checksum + trailer word).
package fpga_cfg_pkg;

    localparam int unsigned DEF_CFG_WIDTH     = 224;
    localparam int unsigned DEF_NUM_FRAMES    = 245;
    localparam int unsigned DEF_SETTLE_CYCLES = 10;
    localparam int unsigned DEF_ARM_CYCLES    = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STROBE = 3'd2,
        ST_SETTLE = 3'd3,
        ST_ARM    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } cfg_state_t;

    // Width that holds the largest of the frame count and both delays.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fpga_config_loader_onehot_shift.sv
// Walking one-hot column enable register for the config chain.
// load1 seeds column 0, shift advances one column, clear zeroes it.
module cfg_onehot_shift #(
    parameter int unsigned WIDTH = 245
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load1,
    input  logic             shift,
    input  logic             clear,
    output logic [WIDTH-1:0] q
);

    // One-hot state: seed beats shift beats clear; the MSB shifts out to all-zero.
    always_ff @(posedge clock) begin
        if (rst) begin
            q <= '0;
        end else if (load1) begin
            q <= WIDTH'(1);
        end else if (shift) begin
            q <= q << 1;
        end else if (clear) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Bitstream loader: streams frames into the fabric config chain column by
// column, waits a settle period, raises ff_en, then rdy.
// Optional feature macro: CFG_CHECK_EN (running XOR checksum, trailer word,
// ERROR state); when undefined err is tied low.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CFG_WIDTH     = DEF_CFG_WIDTH,
    parameter int unsigned NUM_FRAMES    = DEF_NUM_FRAMES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned ARM_CYCLES    = DEF_ARM_CYCLES
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CFG_WIDTH-1:0]  bs_data,
    input  logic                  bs_valid,
    output logic                  bs_ready,
    output logic [CFG_WIDTH-1:0]  configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned CNT_W = cnt_width(NUM_FRAMES, SETTLE_CYCLES, ARM_CYCLES);
    localparam logic [CNT_W-1:0] LAST_FRAME  = CNT_W'(NUM_FRAMES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_CYCLES - 1);

    cfg_state_t       state;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] dly_cnt;
    logic             restart;
    logic             accept;
    logic             en_shift;
    logic             en_clear;

    // Status decode and load/reload qualification from the current state.
    always_comb begin
        bs_ready = (state == ST_LOAD);
        accept   = (state == ST_LOAD) && bs_valid;
        busy     = (state == ST_LOAD) || (state == ST_STROBE) ||
                   (state == ST_SETTLE) || (state == ST_ARM);
        restart  = start && ((state == ST_IDLE) || (state == ST_DONE)
`ifdef CFG_CHECK_EN
                             || (state == ST_ERROR)
`endif
                            );
        en_shift = (state == ST_STROBE);
        en_clear = (state == ST_SETTLE) || (state == ST_ARM) || (state == ST_DONE);
    end

    cfg_onehot_shift #(
        .WIDTH (NUM_FRAMES)
    ) u_onehot (
        .clock (clock),
        .rst   (rst),
        .load1 (restart),
        .shift (en_shift),
        .clear (en_clear),
        .q     (configs_en)
    );

`ifdef CFG_CHECK_EN
    localparam logic [CNT_W-1:0] ALL_FRAMES = CNT_W'(NUM_FRAMES);

    logic [CFG_WIDTH-1:0] csum;
    logic                 trailer;

    // After the final strobe frame_cnt reaches NUM_FRAMES: the next word is the trailer.
    assign trailer = (frame_cnt == ALL_FRAMES);

    // Running XOR of accepted frames; err latches on a trailer mismatch.
    always_ff @(posedge clock) begin
        if (rst) begin
            csum <= '0;
            err  <= 1'b0;
        end else if (restart) begin
            csum <= '0;
            err  <= 1'b0;
        end else if (accept && !trailer) begin
            csum <= csum ^ bs_data;
        end else if (accept && trailer && (bs_data != csum)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Load sequencer: frame capture, strobe, settle and arm timing.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= ST_IDLE;
            configs_in <= '0;
            frame_cnt  <= '0;
            dly_cnt    <= '0;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
        end else if (restart) begin
            state     <= ST_LOAD;
            frame_cnt <= '0;
            dly_cnt   <= '0;
            ff_en     <= 1'b0;
            rdy       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
`ifdef CFG_CHECK_EN
                        if (trailer) begin
                            dly_cnt <= '0;
                            state   <= (bs_data == csum) ? ST_SETTLE : ST_ERROR;
                        end else begin
                            configs_in <= bs_data;
                            state      <= ST_STROBE;
                        end
`else
                        configs_in <= bs_data;
                        state      <= ST_STROBE;
`endif
                    end
                end
                ST_STROBE: begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                    dly_cnt   <= '0;
                    if (frame_cnt == LAST_FRAME) begin
`ifdef CFG_CHECK_EN
                        state <= ST_LOAD;
`else
                        state <= ST_SETTLE;
`endif
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (dly_cnt == SETTLE_LAST) begin
                        dly_cnt <= '0;
                        ff_en   <= 1'b1;
                        state   <= ST_ARM;
                    end else begin
                        dly_cnt <= dly_cnt + CNT_W'(1);
                    end
                end
                ST_ARM: begin
                    if (dly_cnt == ARM_LAST) begin
                        dly_cnt <= '0;
                        rdy     <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        dly_cnt <= dly_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Self-checking bench for fpga_config_loader (CFG_WIDTH=8, NUM_FRAMES=4,
// SETTLE_CYCLES=3, ARM_CYCLES=2). Honours CFG_CHECK_EN when defined.
module tb_fpga_config_loader;

    localparam int CW = 8;
    localparam int NF = 4;
    localparam int SC = 3;
    localparam int AC = 2;
`ifdef CFG_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clock;
    logic          rst;
    logic          start;
    logic [CW-1:0] bs_data;
    logic          bs_valid;
    logic          bs_ready;
    logic [CW-1:0] configs_in;
    logic [NF-1:0] configs_en;
    logic          ff_en;
    logic          rdy;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    fpga_config_loader #(
        .CFG_WIDTH     (CW),
        .NUM_FRAMES    (NF),
        .SETTLE_CYCLES (SC),
        .ARM_CYCLES    (AC)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .bs_data    (bs_data),
        .bs_valid   (bs_valid),
        .bs_ready   (bs_ready),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy),
        .busy       (busy),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frames accepted so far plus cycle timestamps of the
    // end of loading; outputs follow from elapsed cycles.
    int            cyc        = 0;
    bit            m_started  = 1'b0;
    int            m_nacc     = 0;
    int            m_last_hs  = -10;
    int            m_tset     = 0;
    bit            m_trl_done = 1'b0;
    bit            m_err      = 1'b0;
    logic [CW-1:0] m_xor      = '0;
    logic [CW-1:0] m_cin      = '0;

    always @(negedge clock) begin : model_cmp
        bit            strobe;
        bit            load_ph;
        int            d;
        logic [NF-1:0] e_en;
        logic          e_bsr, e_busy, e_ff, e_rdy;
        if (run_cmp) begin
            strobe  = m_started && (m_nacc > 0) && (cyc == m_last_hs + 1);
            load_ph = m_started && ((m_nacc < NF) || strobe || (CHK && !m_trl_done));
            e_en = '0; e_bsr = 1'b0; e_busy = 1'b0; e_ff = 1'b0; e_rdy = 1'b0;
            if (load_ph) begin
                e_busy = 1'b1;
                e_bsr  = !strobe;
                if (strobe)          e_en = NF'(1 << (m_nacc - 1));
                else if (m_nacc < NF) e_en = NF'(1 << m_nacc);
            end else if (m_started) begin
                d      = cyc - m_tset;
                e_ff   = (d >= SC);
                e_rdy  = (d >= SC + AC);
                e_busy = (d < SC + AC);
            end
            check("m_configs_en", 32'(configs_en), 32'(e_en));
            check("m_configs_in", 32'(configs_in), 32'(m_cin));
            check("m_bs_ready",   32'(bs_ready),   32'(e_bsr));
            check("m_busy",       32'(busy),       32'(e_busy));
            check("m_ff_en",      32'(ff_en),      32'(e_ff));
            check("m_rdy",        32'(rdy),        32'(e_rdy));
            check("m_err",        32'(err),        32'(m_err));
            if (rst) begin
                m_started = 1'b0; m_nacc = 0; m_last_hs = -10; m_trl_done = 1'b0;
                m_err = 1'b0; m_xor = '0; m_cin = '0;
            end else if (start && !e_busy) begin
                m_started = 1'b1; m_nacc = 0; m_last_hs = -10; m_trl_done = 1'b0;
                m_err = 1'b0; m_xor = '0;
            end else if (e_bsr && bs_valid) begin
                if (m_nacc < NF) begin
                    m_nacc++;
                    m_last_hs = cyc;
                    m_xor     = m_xor ^ bs_data;
                    m_cin     = bs_data;
                    if (m_nacc == NF && !CHK) m_tset = cyc + 2;
                end else if (bs_data == m_xor) begin
                    m_trl_done = 1'b1;
                    m_tset     = cyc + 1;
                end else begin
                    m_started = 1'b0;
                    m_err     = 1'b1;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clock);
        check("start_en", 32'(configs_en), 32'h1);
        check("start_ready", 32'(bs_ready), 32'h1);
        step();
    endtask

    task automatic wait_hs(input logic [CW-1:0] d);
        int k;
        k = 0;
        bs_valid = 1'b1;
        bs_data  = d;
        @(negedge clock);
        while (!bs_ready && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("hs_bound", 32'(bs_ready), 32'h1);
        step();
        bs_valid = 1'b0;
    endtask

    // Frame handshake, then check the frame/enable pairing in the strobe cycle.
    task automatic send(input logic [CW-1:0] d, input logic [NF-1:0] en);
        wait_hs(d);
        @(negedge clock);
        check("pair_data", 32'(configs_in), 32'(d));
        check("pair_en",   32'(configs_en), 32'(en));
        step();
    endtask

    task automatic finish_load();
`ifdef CFG_CHECK_EN
        wait_hs(8'h04);
`endif
    endtask

    task automatic load_frames();
        send(8'hA1, 4'b0001);
        send(8'hB2, 4'b0010);
        send(8'hC3, 4'b0100);
        send(8'hD4, 4'b1000);
        finish_load();
    endtask

    // Edges from the final enable shift to ff_en, then ff_en to rdy.
    task automatic measure(input int k0);
        int k, j;
        k = k0;
        @(negedge clock);
        check("en_cleared", 32'(configs_en), 32'h0);
        while (!ff_en && k < 30) begin
            @(negedge clock);
            k++;
        end
        check("settle_len", 32'(k), 32'd3);
        j = 0;
        while (!rdy && j < 30) begin
            @(negedge clock);
            j++;
        end
        check("arm_len", 32'(j), 32'd2);
        check("last_frame_held", 32'(configs_in), 32'hD4);
        step();
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, "_in"},   32'(configs_in), 32'h0);
        check({nm, "_en"},   32'(configs_en), 32'h0);
        check({nm, "_ff"},   32'(ff_en),      32'h0);
        check({nm, "_rdy"},  32'(rdy),        32'h0);
        check({nm, "_busy"}, 32'(busy),       32'h0);
        check({nm, "_bsr"},  32'(bs_ready),   32'h0);
        check({nm, "_err"},  32'(err),        32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
        step();
        run_cmp = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clock);
        check_idle_zero("reset");
        step();

        // 1: back-to-back frames
        pulse_start();
        load_frames();
        measure(0);

        // 2: 5-cycle valid gap before frame 2
        pulse_start();
        send(8'hA1, 4'b0001);
        send(8'hB2, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("gap_ready", 32'(bs_ready), 32'h1);
            check("gap_en", 32'(configs_en), 32'b0100);
            step();
        end
        send(8'hC3, 4'b0100);
        send(8'hD4, 4'b1000);
        finish_load();
        measure(0);

        // 3: start pulse during SETTLE is ignored
        pulse_start();
        load_frames();
        start = 1'b1;
        step();
        start = 1'b0;
        measure(1);

        // 4: reset after frame 1 accepted
        pulse_start();
        send(8'hA1, 4'b0001);
        send(8'hB2, 4'b0010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clock);
        check_idle_zero("midreset");
        step();
        pulse_start();
        load_frames();
        measure(0);

        // 5: start in DONE drops ff_en/rdy and reloads
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clock);
        check("reload_ff", 32'(ff_en), 32'h0);
        check("reload_rdy", 32'(rdy), 32'h0);
        check("reload_busy", 32'(busy), 32'h1);
        check("reload_en", 32'(configs_en), 32'h1);
        step();
        load_frames();
        measure(0);

`ifdef CFG_CHECK_EN
        // 6: bad trailer
        pulse_start();
        send(8'hA1, 4'b0001);
        send(8'hB2, 4'b0010);
        send(8'hC3, 4'b0100);
        send(8'hD4, 4'b1000);
        wait_hs(8'h05);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("bad_err", 32'(err), 32'h1);
            check("bad_ff", 32'(ff_en), 32'h0);
            check("bad_busy", 32'(busy), 32'h0);
            step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clock);
        check("err_cleared", 32'(err), 32'h0);
        step();
        load_frames();
        measure(0);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
